// File: rtl/spgd_adc_avg.sv
// Settle-then-average ADC metric sampler feeding the SPGD system block.
// Define SPGD_ADC_SIGNED_EN for two's-complement RAW_DATA (MSB flipped to offset binary).
module spgd_adc_avg #(
  parameter int FP_WIDTH     = 32,
  parameter int FRAC_WIDTH   = 16,
  parameter int RAW_WIDTH    = 14,
  parameter int LOG2_SAMPLES = 4,
  parameter int SETTLE_WIDTH = 16
) (
  input  logic                    ADC_CLK,
  input  logic                    REG_RST,
  input  logic                    ADC_EN,
  input  logic [RAW_WIDTH-1:0]    RAW_DATA,
  input  logic                    RAW_VALID,
  input  logic [SETTLE_WIDTH-1:0] SETTLE,
  output logic [FP_WIDTH-1:0]     ADC_OUT,
  output logic                    ADC_DONE,
  output logic                    BUSY
);

  localparam int ACC_WIDTH = RAW_WIDTH + LOG2_SAMPLES;
  localparam int OUT_SHIFT = FRAC_WIDTH - RAW_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_ACCUM,
    S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [SETTLE_WIDTH-1:0] settle_cnt_q, settle_cnt_d;
  logic [LOG2_SAMPLES-1:0] smp_cnt_q, smp_cnt_d;
  logic [ACC_WIDTH-1:0]    acc_q, acc_d, acc_sum;
  logic [FP_WIDTH-1:0]     out_q, out_d, out_value;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;
  logic [RAW_WIDTH-1:0]    sample;
  logic                    complete;

`ifdef SPGD_ADC_SIGNED_EN
  assign sample = {~RAW_DATA[RAW_WIDTH-1], RAW_DATA[RAW_WIDTH-2:0]};
`else
  assign sample = RAW_DATA;
`endif

  assign acc_sum   = acc_q + {{LOG2_SAMPLES{1'b0}}, sample};
  // Truncating average placed so full-scale raw lands just under 1.0.
  assign out_value = FP_WIDTH'(acc_sum >> LOG2_SAMPLES) << OUT_SHIFT;

  always_ff @(posedge ADC_CLK) begin
    if (REG_RST) begin
      state_q      <= S_IDLE;
      settle_cnt_q <= '0;
      smp_cnt_q    <= '0;
      acc_q        <= '0;
      out_q        <= '0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      smp_cnt_q    <= smp_cnt_d;
      acc_q        <= acc_d;
      out_q        <= out_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    smp_cnt_d    = smp_cnt_q;
    acc_d        = acc_q;
    complete     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ADC_EN) begin
          state_d      = S_SETTLE;
          settle_cnt_d = SETTLE;
          smp_cnt_d    = '0;
          acc_d        = '0;
        end
      end
      S_SETTLE: begin
        if (!ADC_EN) begin
          state_d = S_IDLE;
        end else if (settle_cnt_q == '0) begin
          state_d = S_ACCUM;
        end else begin
          settle_cnt_d = settle_cnt_q - SETTLE_WIDTH'(1);
        end
      end
      S_ACCUM: begin
        // Abort wins over a final sample arriving in the same cycle.
        if (!ADC_EN) begin
          state_d = S_IDLE;
        end else if (RAW_VALID) begin
          acc_d     = acc_sum;
          smp_cnt_d = smp_cnt_q + LOG2_SAMPLES'(1);
          if (smp_cnt_q == '1) begin
            state_d  = S_DONE;
            complete = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (!ADC_EN) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_d = (state_d == S_SETTLE) || (state_d == S_ACCUM);
    done_d = (state_d == S_DONE);
    out_d  = complete ? out_value : out_q;
  end

  assign ADC_OUT  = out_q;
  assign ADC_DONE = done_q;
  assign BUSY     = busy_q;

endmodule

// File: tb/tb_spgd_adc_avg.sv
// Self-checking bench for spgd_adc_avg; expectations come from a sample-list average model.
module tb_spgd_adc_avg;

  localparam int N_SAMPLES = 16;
  localparam int SCALE     = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        valid;
  logic [13:0] raw;
  logic [15:0] settle;
  logic [31:0] adc_out;
  logic        done;
  logic        busy;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [31:0] last_out;

  always #5 clk = ~clk;

  spgd_adc_avg #(
    .FP_WIDTH    (32),
    .FRAC_WIDTH  (16),
    .RAW_WIDTH   (14),
    .LOG2_SAMPLES(4),
    .SETTLE_WIDTH(16)
  ) dut (
    .ADC_CLK  (clk),
    .REG_RST  (rst),
    .ADC_EN   (en),
    .RAW_DATA (raw),
    .RAW_VALID(valid),
    .SETTLE   (settle),
    .ADC_OUT  (adc_out),
    .ADC_DONE (done),
    .BUSY     (busy)
  );

  function automatic int unsigned mval(input logic [13:0] r);
`ifdef SPGD_ADC_SIGNED_EN
    return 32'(r ^ 14'h2000);
`else
    return 32'(r);
`endif
  endfunction

  function automatic logic [31:0] expect_out(input int unsigned sum);
    return 32'((sum / N_SAMPLES) * SCALE);
  endfunction

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; valid = 1'b1; raw = 14'h1234; settle = 16'd3;
    repeat (3) begin
      @(negedge clk);
      total++; if (adc_out !== 32'h0) begin bad++; $display("FAIL reset_out got=%h exp=%h", adc_out, 32'h0); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    end
    rst = 1'b0; en = 1'b0; valid = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
    last_out = 32'h0;
  endtask

  // Request seen at edge 0; DONE is set by edge 22 and so sampled high at edge 23.
  task automatic test_constant();
    logic [31:0] exp_o;
    settle = 16'd5; raw = 14'h2000; valid = 1'b1; en = 1'b1;
    exp_o = expect_out(N_SAMPLES * mval(14'h2000));
    @(negedge clk);
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      total++; if (done !== (k == 22)) begin bad++; $display("FAIL const_done_edge%0d got=%b exp=%b", k, done, (k == 22)); end
    end
    total++; if (adc_out !== exp_o) begin bad++; $display("FAIL const_out got=%h exp=%h", adc_out, exp_o); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL const_busy got=%b exp=0", busy); end
    last_out = exp_o;
    repeat (4) begin
      @(negedge clk);
      total++; if (done !== 1'b1 || adc_out !== exp_o) begin bad++; $display("FAIL const_hold got=%b/%h exp=1/%h", done, adc_out, exp_o); end
    end
    en = 1'b0;
    @(negedge clk);
    total++; if (done !== 1'b0 || adc_out !== exp_o) begin bad++; $display("FAIL const_release got=%b/%h exp=0/%h", done, adc_out, exp_o); end
  endtask

  task automatic test_gapped_ramp();
    int unsigned sum = 0;
    logic [31:0] exp_o;
    settle = 16'd0; en = 1'b1; valid = 1'b0; raw = 14'd0;
    @(negedge clk);
    raw = 14'd99; valid = 1'b1;
    @(negedge clk);
    for (int unsigned i = 0; i < 16; i++) begin
      raw = 14'(i); valid = 1'b1;
      @(negedge clk);
      sum += mval(14'(i));
      total++; if (done !== (i == 15)) begin bad++; $display("FAIL ramp_done_s%0d got=%b exp=%b", i, done, (i == 15)); end
      if (i != 15) begin
        raw = 14'd1000; valid = 1'b0;
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL ramp_gap_s%0d got=%b exp=0", i, done); end
      end
    end
    exp_o = expect_out(sum);
    total++; if (adc_out !== exp_o) begin bad++; $display("FAIL ramp_out got=%h exp=%h", adc_out, exp_o); end
    last_out = exp_o;
    en = 1'b0; valid = 1'b0;
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL ramp_release got=%b exp=0", done); end
  endtask

  task automatic test_abort();
    settle = 16'd2; raw = 14'h3FFF; valid = 1'b1; en = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      total++; if (done !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL abort_run_edge%0d got=%b/%b exp=0/1", k, done, busy); end
    end
    en = 1'b0;
    repeat (4) begin
      @(negedge clk);
      total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL abort_idle got=%b/%b exp=0/0", done, busy); end
      total++; if (adc_out !== last_out) begin bad++; $display("FAIL abort_out got=%h exp=%h", adc_out, last_out); end
    end
  endtask

  task automatic test_back_to_back();
    int unsigned rises = 0;
    logic prev = 1'b0;
    logic [13:0] v;
    logic [31:0] exp_o;
    bit got;
    v = 14'($urandom);
    exp_o = expect_out(N_SAMPLES * mval(v));
    settle = 16'd1; raw = v; valid = 1'b1; en = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (done && !prev) rises++;
      prev = done;
    end
    total++; if (rises != 1) begin bad++; $display("FAIL b2b_rises got=%0d exp=1", rises); end
    total++; if (adc_out !== exp_o) begin bad++; $display("FAIL b2b_out1 got=%h exp=%h", adc_out, exp_o); end
    en = 1'b0;
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL b2b_gap got=%b exp=0", done); end
    v = 14'($urandom);
    exp_o = expect_out(N_SAMPLES * mval(v));
    raw = v; en = 1'b1; got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      got = done;
    end
    total++; if (!got) begin bad++; $display("FAIL b2b_timeout done=0 required=1"); end
    total++; if (adc_out !== exp_o) begin bad++; $display("FAIL b2b_out2 got=%h exp=%h", adc_out, exp_o); end
    last_out = exp_o;
    en = 1'b0;
    @(negedge clk);
  endtask

  // Samples presented before edges 1..SETTLE+1 are ignored; from edge SETTLE+2 valid ones count.
  task automatic test_random(input int unsigned iters);
    for (int unsigned it = 0; it < iters; it++) begin
      int unsigned st, cnt, sum, k;
      bit finished;
      st = $urandom_range(0, 6);
      settle = 16'(st); en = 1'b1; valid = 1'b0; raw = 14'($urandom);
      @(negedge clk);
      settle = 16'($urandom);
      cnt = 0; sum = 0; k = 1; finished = 1'b0;
      while (!finished && k < 300) begin
        raw = 14'($urandom);
        valid = ($urandom_range(0, 2) != 0);
        @(negedge clk);
        if (k >= st + 2 && valid) begin
          sum += mval(raw);
          cnt++;
        end
        finished = (cnt == N_SAMPLES);
        total++; if (done !== finished) begin bad++; $display("FAIL rand%0d_done_edge%0d got=%b exp=%b", it, k, done, finished); end
        total++; if (busy !== !finished) begin bad++; $display("FAIL rand%0d_busy_edge%0d got=%b exp=%b", it, k, busy, !finished); end
        k++;
      end
      if (!finished) begin
        total++; bad++; $display("FAIL rand%0d_timeout done=%b required=1", it, done);
      end else begin
        total++; if (adc_out !== expect_out(sum)) begin bad++; $display("FAIL rand%0d_out got=%h exp=%h", it, adc_out, expect_out(sum)); end
        last_out = expect_out(sum);
      end
      en = 1'b0; valid = 1'b0;
      @(negedge clk);
      total++; if (done !== 1'b0 || adc_out !== last_out) begin bad++; $display("FAIL rand%0d_release got=%b/%h exp=0/%h", it, done, adc_out, last_out); end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; valid = 1'b0; raw = '0; settle = '0;
    last_out = '0;
    test_reset();
    test_constant();
    test_gapped_ramp();
    test_abort();
    test_back_to_back();
    test_random(8);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
